// File: rtl/rs_encoder_serial.sv
// Serial systematic RS(n,k) encoder: k message symbols pass straight through, then 2t LFSR parity symbols follow.
// Defining RS_ENC_ERR_INJECT_EN adds an output-side symbol error injector (inj_en/inj_pos/inj_val).
module rs_encoder_serial #(
  parameter int         N         = 255,
  parameter int         K         = 239,
  parameter int         T         = 8,
  parameter int         M         = 8,
  parameter logic [M:0] PRIM_POLY = 9'h11D
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         in_valid,
  input  logic         in_sop,
  input  logic [M-1:0] data_in,
`ifdef RS_ENC_ERR_INJECT_EN
  input  logic         inj_en,
  input  logic [7:0]   inj_pos,
  input  logic [M-1:0] inj_val,
`endif
  output logic         in_ready,
  output logic         out_valid,
  output logic         out_sop,
  output logic         out_eop,
  output logic [M-1:0] data_out,
  output logic         frame_abort
);

  localparam int P  = 2 * T;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_MSG = CW'(K - 1);
  localparam logic [CW-1:0] LAST_PAR = CW'(P - 1);

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x[M-1] ? ((x << 1) ^ PRIM_POLY[M-1:0]) : (x << 1);
    end
    return acc;
  endfunction

  // Expands prod (x + alpha^i), i = 0..2t-1; the monic leading term is implicit.
  function automatic logic [P*M-1:0] gen_poly();
    logic [M-1:0]   g [P+1];
    logic [M-1:0]   root;
    logic [P*M-1:0] gp;
    for (int j = 0; j <= P; j++) g[j] = '0;
    g[0] = M'(1);
    root = M'(1);
    for (int i = 0; i < P; i++) begin
      for (int j = i + 1; j >= 1; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, M'(2));
    end
    for (int j = 0; j < P; j++) gp[j*M +: M] = g[j];
    return gp;
  endfunction

  localparam logic [P*M-1:0] G = gen_poly();

  typedef enum logic [1:0] {S_IDLE, S_MSG, S_PARITY} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]    lfsr_q [P];
  logic [M-1:0]    lfsr_d [P];
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            out_sop_q, out_sop_d;
  logic            out_eop_q, out_eop_d;
  logic            frame_abort_q, frame_abort_d;
  logic [M-1:0]    data_out_q, data_out_d;
  logic [M-1:0]    data_clean;
  logic            accept;
  logic            sop_acc;
  logic [CW-1:0]   base_cnt;
  logic [M-1:0]    fb;

  // NOTE: every value written here gets a default first, so no path can leave a latch behind.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = 1'b0;
    out_sop_d     = 1'b0;
    out_eop_d     = 1'b0;
    frame_abort_d = 1'b0;
    data_clean    = data_out_q;
    accept        = in_valid & in_ready_q;
    sop_acc       = accept & in_sop;
    base_cnt      = sop_acc ? {CW{1'b0}} : cnt_q;
    fb            = sop_acc ? data_in : (data_in ^ lfsr_q[P-1]);
    case (state_q)
      S_IDLE, S_MSG: begin
        // A sop restarts the division from a cleared LFSR, even mid-frame.
        if (accept && (sop_acc || state_q == S_MSG)) begin
          frame_abort_d = sop_acc && (state_q == S_MSG);
          out_valid_d   = 1'b1;
          out_sop_d     = sop_acc;
          data_clean    = data_in;
          lfsr_d[0]     = gf_mul(fb, G[M-1:0]);
          for (int j = 1; j < P; j++)
            lfsr_d[j] = (sop_acc ? {M{1'b0}} : lfsr_q[j-1]) ^ gf_mul(fb, G[j*M +: M]);
          if (base_cnt == LAST_MSG) begin
            state_d    = S_PARITY;
            cnt_d      = '0;
            in_ready_d = 1'b0;
          end else begin
            state_d = S_MSG;
            cnt_d   = base_cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        out_valid_d = 1'b1;
        data_clean  = lfsr_q[P-1];
        for (int j = P - 1; j >= 1; j--) lfsr_d[j] = lfsr_q[j-1];
        lfsr_d[0] = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_PAR) begin
          out_eop_d  = 1'b1;
          for (int j = 0; j < P; j++) lfsr_d[j] = '0;
          cnt_d      = '0;
          state_d    = S_IDLE;
          in_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef RS_ENC_ERR_INJECT_EN
  logic         inj_arm_q, inj_arm_d;
  logic [7:0]   inj_pos_q, inj_pos_d;
  logic [M-1:0] inj_val_q, inj_val_d;
  int           sym_idx;
  logic         inj_hit;

  // Injection settings are captured with the sop symbol; the LFSR only ever sees data_clean.
  always_comb begin
    inj_arm_d = inj_arm_q;
    inj_pos_d = inj_pos_q;
    inj_val_d = inj_val_q;
    if (sop_acc) begin
      inj_arm_d = inj_en;
      inj_pos_d = inj_pos;
      inj_val_d = inj_val;
    end
    sym_idx    = (state_q == S_PARITY) ? (K + int'(cnt_q)) : int'(base_cnt);
    inj_hit    = inj_arm_d && out_valid_d && (int'(inj_pos_d) == sym_idx) && (int'(inj_pos_d) < N);
    data_out_d = inj_hit ? (data_clean ^ inj_val_d) : data_clean;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      inj_arm_q <= 1'b0;
      inj_pos_q <= '0;
      inj_val_q <= '0;
    end else begin
      inj_arm_q <= inj_arm_d;
      inj_pos_q <= inj_pos_d;
      inj_val_q <= inj_val_d;
    end
  end
`else
  assign data_out_d = data_clean;
`endif

  // NOTE: sequential state is only ever assigned with <=; all next-state math lives in always_comb.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      frame_abort_q <= 1'b0;
      data_out_q    <= '0;
      // NOTE: the LFSR is a small flop array, not a RAM, so it is cleared explicitly on reset.
      for (int j = 0; j < P; j++) lfsr_q[j] <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      frame_abort_q <= frame_abort_d;
      data_out_q    <= data_out_d;
      lfsr_q        <= lfsr_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign data_out    = data_out_q;
  assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_rs_encoder_serial.sv
// Bench for rs_encoder_serial: codewords checked against a polynomial long-division model and root syndromes.
// Build with RS_ENC_ERR_INJECT_EN defined to also cover the error injector.
module tb_rs_encoder_serial;

  localparam int N = 255;
  localparam int K = 239;
  localparam int P = 16;

  logic       clk_in = 1'b0;
  logic       rst_in, in_valid, in_sop;
  logic [7:0] data_in;
  logic       in_ready, out_valid, out_sop, out_eop, frame_abort;
  logic [7:0] data_out;
`ifdef RS_ENC_ERR_INJECT_EN
  logic       inj_en;
  logic [7:0] inj_pos, inj_val;
  logic       cfg_inj_en;
  logic [7:0] cfg_inj_pos, cfg_inj_val;
`endif

  rs_encoder_serial dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .in_valid    (in_valid),
    .in_sop      (in_sop),
    .data_in     (data_in),
`ifdef RS_ENC_ERR_INJECT_EN
    .inj_en      (inj_en),
    .inj_pos     (inj_pos),
    .inj_val     (inj_val),
`endif
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .data_out    (data_out),
    .frame_abort (frame_abort)
  );

  always #5 clk_in = ~clk_in;

  int passed = 0;
  int total  = 0;

  // GF(2^8) via exp/log tables built from repeated multiplication by alpha.
  logic [7:0] alpha_pow [255];
  int         log_tab   [256];
  logic [7:0] g_ref     [P+1];
  logic [7:0] msg       [K];
  logic [7:0] msg_a     [K];
  logic [7:0] exp_cw    [N];

  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return alpha_pow[(log_tab[a] + log_tab[b]) % 255];
  endfunction

  task automatic init_model();
    int v;
    v = 1;
    for (int i = 0; i < 255; i++) begin
      alpha_pow[i] = v[7:0];
      log_tab[v]   = i;
      v = v << 1;
      if (v >= 256) v = v ^ 'h11D;
    end
    for (int j = 0; j <= P; j++) g_ref[j] = 8'h00;
    g_ref[0] = 8'h01;
    for (int i = 0; i < P; i++) begin
      for (int j = i + 1; j >= 1; j--) g_ref[j] = g_ref[j-1] ^ gmul_ref(g_ref[j], alpha_pow[i]);
      g_ref[0] = gmul_ref(g_ref[0], alpha_pow[i]);
    end
  endtask

  // Codeword = message followed by the remainder of m(x)*x^2t divided by g(x), highest degree first.
  task automatic compute_expected();
    logic [7:0] w [N];
    logic [7:0] coef;
    for (int i = 0; i < N; i++) w[i] = (i < K) ? msg[i] : 8'h00;
    for (int i = 0; i < K; i++) begin
      coef = w[i];
      if (coef != 0)
        for (int j = 0; j <= P; j++) w[i+j] = w[i+j] ^ gmul_ref(coef, g_ref[P-j]);
    end
    for (int i = 0; i < N; i++) exp_cw[i] = (i < K) ? msg[i] : w[i];
  endtask

  typedef struct {
    logic       sop;
    logic       eop;
    logic       abort;
    logic [7:0] d;
    int         cyc;
  } sym_t;

  sym_t out_q[$];
  int   cyc = 0;
  int   ready_low = 0;
  int   abort_cnt = 0;
  bit   eop_seen = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (!in_ready) ready_low++;
    if (frame_abort) abort_cnt++;
    if (out_valid) begin
      sym_t s;
      s.sop   = out_sop;
      s.eop   = out_eop;
      s.abort = frame_abort;
      s.d     = data_out;
      s.cyc   = cyc;
      out_q.push_back(s);
      if (out_eop) eop_seen = 1'b1;
    end
  end

  task automatic clear_mon();
    out_q.delete();
    ready_low = 0;
    abort_cnt = 0;
    eop_seen  = 1'b0;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    data_in  = 8'h00;
`ifdef RS_ENC_ERR_INJECT_EN
    inj_en  = 1'b0;
    inj_pos = 8'h00;
    inj_val = 8'h00;
`endif
  endtask

  task automatic random_msg();
    for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
  endtask

  // Sends msg[0..count-1] with sop on the first; stall inserts idle cycles with 50% probability.
  task automatic send_syms(input int count, input bit stall);
    for (int i = 0; i < count; i++) begin
      if (stall && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_sop   = 1'($urandom);
        data_in  = 8'($urandom);
        @(posedge clk_in); #1;
      end
      in_valid = 1'b1;
      in_sop   = (i == 0);
      data_in  = msg[i];
`ifdef RS_ENC_ERR_INJECT_EN
      inj_en  = (i == 0) ? cfg_inj_en : 1'b0;
      inj_pos = cfg_inj_pos;
      inj_val = cfg_inj_val;
`endif
      @(posedge clk_in); #1;
    end
  endtask

  task automatic finish_frame(input string name);
    int c;
    idle_inputs();
    c = 0;
    while (!eop_seen && c < 300) begin
      @(posedge clk_in); #1;
      c++;
    end
    total++;
    if (!eop_seen) $display("FAIL %s timeout: out_eop not seen within %0d cycles", name, c);
    else passed++;
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    total++;
    if ({in_ready, out_valid, out_sop, out_eop, frame_abort, data_out} !== {1'b1, 4'b0000, 8'h00})
      $display("FAIL reset_state: got rdy=%b v=%b sop=%b eop=%b abort=%b d=%h, expected rdy=1 others 0",
               in_ready, out_valid, out_sop, out_eop, frame_abort, data_out);
    else passed++;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
  endtask

  task automatic test_idle_drop();
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_sop   = 1'b0;
      data_in  = 8'($urandom);
      @(posedge clk_in); #1;
    end
    idle_inputs();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    total++;
    if (out_q.size() !== 0 || in_ready !== 1'b1)
      $display("FAIL idle_drop: got %0d output symbols rdy=%b, expected 0 symbols rdy=1", out_q.size(), in_ready);
    else passed++;
    @(posedge clk_in); #1;
  endtask

  task automatic test_zero_msg();
    for (int i = 0; i < K; i++) msg[i] = 8'h00;
    clear_mon();
    send_syms(K, 1'b0);
    finish_frame("zero_msg");
    total++;
    if (out_q.size() !== N) $display("FAIL zero_msg length: got %0d, expected %0d", out_q.size(), N);
    else passed++;
    for (int i = 0; i < N && i < out_q.size(); i++) begin
      total++;
      if ({out_q[i].sop, out_q[i].eop, out_q[i].d} !== {i == 0, i == N - 1, 8'h00})
        $display("FAIL zero_msg sym %0d: got sop=%b eop=%b d=%h, expected sop=%b eop=%b d=00",
                 i, out_q[i].sop, out_q[i].eop, out_q[i].d, i == 0, i == N - 1);
      else passed++;
    end
    if (out_q.size() == N) begin
      total++;
      if (out_q[N-1].cyc - out_q[0].cyc !== N - 1)
        $display("FAIL zero_msg span: got %0d cycles, expected %0d", out_q[N-1].cyc - out_q[0].cyc, N - 1);
      else passed++;
    end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < K; i++) msg[i] = 8'h00;
    msg[K-1] = 8'h01;
    compute_expected();
    clear_mon();
    send_syms(K, 1'b0);
    finish_frame("impulse");
    total++;
    if (out_q.size() !== N) $display("FAIL impulse length: got %0d, expected %0d", out_q.size(), N);
    else passed++;
    if (out_q.size() == N) begin
      for (int i = 0; i < N; i++) begin
        total++;
        if (out_q[i].d !== exp_cw[i]) $display("FAIL impulse sym %0d: got %h, expected %h", i, out_q[i].d, exp_cw[i]);
        else passed++;
      end
      for (int i = 0; i < P; i++) begin
        total++;
        if (out_q[K+i].d !== g_ref[P-1-i])
          $display("FAIL impulse g coef %0d: got %h, expected %h", P - 1 - i, out_q[K+i].d, g_ref[P-1-i]);
        else passed++;
      end
      total++;
      if (out_q[N-1].d !== alpha_pow[120])
        $display("FAIL impulse g0: got %h, expected alpha^120=%h", out_q[N-1].d, alpha_pow[120]);
      else passed++;
    end
  endtask

  task automatic test_random_stall();
    logic [7:0] s;
    random_msg();
    compute_expected();
    clear_mon();
    send_syms(K, 1'b0);
    finish_frame("random_nostall");
    total++;
    if (out_q.size() !== N) $display("FAIL random_nostall length: got %0d, expected %0d", out_q.size(), N);
    else passed++;
    if (out_q.size() == N) begin
      for (int i = 0; i < N; i++) begin
        total++;
        if (out_q[i].d !== exp_cw[i]) $display("FAIL random_nostall sym %0d: got %h, expected %h", i, out_q[i].d, exp_cw[i]);
        else passed++;
      end
      // Every root alpha^r of g(x) must also be a root of the emitted codeword.
      for (int r = 0; r < P; r++) begin
        s = 8'h00;
        for (int i = 0; i < N; i++) s = gmul_ref(s, alpha_pow[r]) ^ out_q[i].d;
        total++;
        if (s !== 8'h00) $display("FAIL random_syndrome %0d: got %h, expected 00", r, s);
        else passed++;
      end
    end
    clear_mon();
    send_syms(K, 1'b1);
    finish_frame("random_stall");
    total++;
    if (out_q.size() !== N) $display("FAIL random_stall length: got %0d, expected %0d", out_q.size(), N);
    else passed++;
    for (int i = 0; i < N && i < out_q.size(); i++) begin
      total++;
      if ({out_q[i].sop, out_q[i].eop, out_q[i].d} !== {i == 0, i == N - 1, exp_cw[i]})
        $display("FAIL random_stall sym %0d: got sop=%b eop=%b d=%h, expected sop=%b eop=%b d=%h",
                 i, out_q[i].sop, out_q[i].eop, out_q[i].d, i == 0, i == N - 1, exp_cw[i]);
      else passed++;
    end
    total++;
    if (ready_low !== P) $display("FAIL random_stall in_ready low: got %0d cycles, expected %0d", ready_low, P);
    else passed++;
  endtask

  task automatic test_abort();
    random_msg();
    for (int i = 0; i < K; i++) msg_a[i] = msg[i];
    clear_mon();
    send_syms(100, 1'b0);
    random_msg();
    compute_expected();
    send_syms(K, 1'b0);
    finish_frame("abort");
    total++;
    if (out_q.size() !== 100 + N) $display("FAIL abort length: got %0d, expected %0d", out_q.size(), 100 + N);
    else passed++;
    total++;
    if (abort_cnt !== 1) $display("FAIL abort pulses: got %0d, expected 1", abort_cnt);
    else passed++;
    if (out_q.size() == 100 + N) begin
      for (int i = 0; i < 100; i++) begin
        total++;
        if ({out_q[i].sop, out_q[i].eop, out_q[i].d} !== {i == 0, 1'b0, msg_a[i]})
          $display("FAIL abort partial sym %0d: got sop=%b eop=%b d=%h, expected sop=%b eop=0 d=%h",
                   i, out_q[i].sop, out_q[i].eop, out_q[i].d, i == 0, msg_a[i]);
        else passed++;
      end
      total++;
      if (out_q[100].abort !== 1'b1) $display("FAIL abort alignment: got frame_abort=%b at new sop, expected 1", out_q[100].abort);
      else passed++;
      for (int i = 0; i < N; i++) begin
        total++;
        if ({out_q[100+i].sop, out_q[100+i].eop, out_q[100+i].d} !== {i == 0, i == N - 1, exp_cw[i]})
          $display("FAIL abort new sym %0d: got sop=%b eop=%b d=%h, expected sop=%b eop=%b d=%h",
                   i, out_q[100+i].sop, out_q[100+i].eop, out_q[100+i].d, i == 0, i == N - 1, exp_cw[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_midframe();
    random_msg();
    clear_mon();
    send_syms(50, 1'b0);
    in_valid = 1'b1;
    in_sop   = 1'b0;
    data_in  = msg[50];
    rst_in   = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    idle_inputs();
    @(negedge clk_in);
    total++;
    if ({in_ready, out_valid, out_sop, out_eop, frame_abort, data_out} !== {1'b1, 4'b0000, 8'h00})
      $display("FAIL midreset_state: got rdy=%b v=%b sop=%b eop=%b abort=%b d=%h, expected rdy=1 others 0",
               in_ready, out_valid, out_sop, out_eop, frame_abort, data_out);
    else passed++;
    total++;
    if (out_q.size() !== 50 || eop_seen) $display("FAIL midreset partial: got %0d symbols eop=%b, expected 50 eop=0", out_q.size(), eop_seen);
    else passed++;
    @(posedge clk_in); #1;
    random_msg();
    compute_expected();
    clear_mon();
    send_syms(K, 1'b0);
    finish_frame("midreset_next");
    total++;
    if (out_q.size() !== N) $display("FAIL midreset_next length: got %0d, expected %0d", out_q.size(), N);
    else passed++;
    for (int i = 0; i < N && i < out_q.size(); i++) begin
      total++;
      if (out_q[i].d !== exp_cw[i]) $display("FAIL midreset_next sym %0d: got %h, expected %h", i, out_q[i].d, exp_cw[i]);
      else passed++;
    end
  endtask

`ifdef RS_ENC_ERR_INJECT_EN
  task automatic test_inject();
    logic [7:0] want;
    for (int pass = 0; pass < 2; pass++) begin
      cfg_inj_en  = 1'b1;
      cfg_inj_pos = (pass == 0) ? 8'd10 : 8'd255;
      cfg_inj_val = 8'h5A;
      random_msg();
      compute_expected();
      clear_mon();
      send_syms(K, 1'b0);
      finish_frame("inject");
      total++;
      if (out_q.size() !== N) $display("FAIL inject length: got %0d, expected %0d", out_q.size(), N);
      else passed++;
      for (int i = 0; i < N && i < out_q.size(); i++) begin
        want = (pass == 0 && i == 10) ? (exp_cw[i] ^ 8'h5A) : exp_cw[i];
        total++;
        if (out_q[i].d !== want) $display("FAIL inject pos=%0d sym %0d: got %h, expected %h", cfg_inj_pos, i, out_q[i].d, want);
        else passed++;
      end
    end
    cfg_inj_en = 1'b0;
  endtask
`endif

  initial begin
    rst_in = 1'b1;
    idle_inputs();
`ifdef RS_ENC_ERR_INJECT_EN
    cfg_inj_en  = 1'b0;
    cfg_inj_pos = 8'h00;
    cfg_inj_val = 8'h00;
`endif
    init_model();
    test_reset();
    test_idle_drop();
    test_zero_msg();
    test_impulse();
    test_random_stall();
    test_abort();
    test_reset_midframe();
`ifdef RS_ENC_ERR_INJECT_EN
    test_inject();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
